lut_config_loader: RTL and testbench
====================================

LUT_CONFIG_LOADER -- requirements
Module: lut_config_loader

Interface
REQ-001 Parameter: WIDTH, default 16, number of configuration bits per load (minimum 2).
REQ-002 Parameter: LSB_FIRST, default 0; 0 = serialise cfg_data[WIDTH-1] first, 1 = cfg_data[0] first.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: cfg_data  input  WIDTH  parallel configuration word; sampled only on handshake.
REQ-006 Port: cfg_valid  input  1  producer asserts while cfg_data holds a word to load.
REQ-007 Port: cfg_ready  output  1  loader can accept a word this cycle.
REQ-008 Port: abort  input  1  cancels an in-progress load.
REQ-009 Port: config_out  output  1  serial configuration bit to the downstream DFF LUT chain.
REQ-010 Port: config_en  output  1  downstream chain shifts config_out in on any rising edge where config_en=1.
REQ-011 Port: busy  output  1  high while a load is in progress (SHIFT or DONE).
REQ-012 Port: done  output  1  one-cycle pulse marking a completed load.

Function
REQ-013 The FSM shall have exactly three states: IDLE, SHIFT and DONE.
REQ-014 The loader shall assert cfg_ready=1 only in IDLE, and cfg_ready shall not depend combinationally on cfg_valid.
REQ-015 Handshake: on the rising edge where cfg_valid=1 and cfg_ready=1, the loader shall capture cfg_data into a WIDTH-bit shift register, load the bit counter with WIDTH, and enter SHIFT.
REQ-016 In SHIFT, config_en shall be 1 and config_out shall be the current head bit of the shift register (MSB or LSB per LSB_FIRST).
REQ-017 On each edge in SHIFT, the loader shall advance the shift register by one bit and decrement the counter.
REQ-018 The first serial bit shall appear on the cycle after the handshake edge, and exactly WIDTH consecutive cycles shall carry config_en=1.
REQ-019 When the counter reaches 1 in SHIFT, the next edge shall enter DONE (the final bit is consumed on that edge).
REQ-020 DONE shall last one cycle: done=1, config_en=0, busy=1; the next edge shall return to IDLE.
REQ-021 Back-to-back throughput: a new handshake is possible no earlier than the first IDLE cycle after DONE, giving a minimum period of WIDTH+2 cycles per word.
REQ-022 Abort in SHIFT: if abort=1 at an edge, the FSM shall go to IDLE on that edge.
REQ-023 After an abort, config_en shall be 0 from the next cycle, done shall not pulse, and the remaining bits shall be discarded.
REQ-024 Abort in IDLE or DONE shall be ignored; abort and cfg_valid together in IDLE shall perform a normal handshake.
REQ-025 Whenever config_en=0, config_out shall be held at 0.
REQ-026 The counter shall be sized ceil(log2(WIDTH+1)) bits and shall never wrap below 0.
REQ-027 cfg_data changes while the loader is not in IDLE shall have no effect on the serial stream.

Reset
REQ-028 On reset_n=0, the loader shall immediately, without waiting for a clock edge, enter IDLE with the shift register and counter cleared and outputs cfg_ready=1, config_en=0, config_out=0, busy=0, done=0.
REQ-029 Reset asserted mid-SHIFT shall terminate the load with no done pulse.
REQ-030 Deassertion of reset_n shall be synchronous to clock, and the first handshake shall be accepted on the first edge after deassertion.

Verification
REQ-031 Reset check: hold reset_n=0 for 3 cycles -> all outputs at REQ-028 values; release and present cfg_data=16'hA5C3 with cfg_valid=1 -> handshake on the first edge.
REQ-032 MSB-first load: WIDTH=16, LSB_FIRST=0, cfg_data=16'hA5C3 -> config_out sequence 1010_0101_1100_0011 over 16 cycles with config_en=1, then done=1 for one cycle, then cfg_ready=1.
REQ-033 LSB-first load: LSB_FIRST=1, cfg_data=16'h0001 -> first serial bit 1, followed by fifteen 0s.
REQ-034 Downstream check: with a 16-bit shift chain enabled by config_en, after a load of 16'hA5C3 the chain holds 16'hA5C3, and select 2'b10 through a 4:1 MUX on bits[3:0] yields the expected bit.
REQ-035 Abort: assert abort on the 5th SHIFT cycle -> config_en=0 from the next cycle, done never pulses, cfg_ready=1, and a new word loads cleanly.
REQ-036 Async reset mid-SHIFT (between clock edges) -> outputs reach reset values before the next edge, with no done pulse.

Source files
------------

// File: rtl/lut_config_loader.sv
// Serial configuration loader: takes a WIDTH-bit word on a valid/ready handshake
// and shifts it out one bit per cycle into a downstream DFF LUT chain.
module lut_config_loader #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             abort,
    output logic             config_out,
    output logic             config_en,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             head_bit;
    logic [WIDTH-1:0] shreg_adv;

    // Head bit and one-bit advance depend only on the serialisation order.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign head_bit  = shreg_q[0];
            assign shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
        end else begin : g_msb_first
            assign head_bit  = shreg_q[WIDTH-1];
            assign shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
        end
    endgenerate

    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    shreg_d = cfg_data;
                    cnt_d   = CNT_LOAD;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    shreg_d = shreg_adv;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                    if (cnt_q <= CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode the registered state only, so cfg_ready never sees cfg_valid.
    assign cfg_ready  = (state_q == IDLE);
    assign config_en  = (state_q == SHIFT);
    assign config_out = config_en & head_bit;
    assign busy       = (state_q == SHIFT) || (state_q == DONE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: MSB-first and LSB-first instances share
// stimulus; a model 16-bit chain and 4:1 mux sit downstream of the MSB instance.
module tb_lut_config_loader;

    logic        clock;
    logic        reset_n;
    logic [15:0] cfg_data;
    logic        cfg_valid;
    logic        abort;

    logic m_ready, m_out, m_en, m_busy, m_done;
    logic l_ready, l_out, l_en, l_busy, l_done;

    logic [15:0] chain;
    int          done_cnt;
    int          errors;
    int          checks;

    lut_config_loader #(.WIDTH(16), .LSB_FIRST(1'b0)) dut_msb (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (m_ready),
        .abort      (abort),
        .config_out (m_out),
        .config_en  (m_en),
        .busy       (m_busy),
        .done       (m_done)
    );

    lut_config_loader #(.WIDTH(16), .LSB_FIRST(1'b1)) dut_lsb (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (l_ready),
        .abort      (abort),
        .config_out (l_out),
        .config_en  (l_en),
        .busy       (l_busy),
        .done       (l_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream DFF chain shifting in the MSB-first stream.
    always @(posedge clock) begin
        if (m_en) chain <= {chain[14:0], m_out};
    end

    initial done_cnt = 0;
    always @(negedge clock) begin
        if (m_done || l_done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ready"}, {30'd0, m_ready, l_ready}, 32'h3);
        check({tag, " en"},    {30'd0, m_en, l_en},       32'h0);
        check({tag, " out"},   {30'd0, m_out, l_out},     32'h0);
        check({tag, " busy"},  {30'd0, m_busy, l_busy},   32'h0);
        check({tag, " done"},  {30'd0, m_done, l_done},   32'h0);
    endtask

    // Full load: handshake, 16 serial bits on both instances, one DONE cycle, back to IDLE.
    task automatic run_load(input logic [15:0] w, input logic abort_at_hs);
        logic [15:0] word;
        word      = w;
        cfg_data  = w;
        cfg_valid = 1'b1;
        abort     = abort_at_hs;
        step();
        cfg_valid = 1'b0;
        abort     = 1'b0;
        cfg_data  = ~w;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%h en[%0d]", w, i), {30'd0, m_en, l_en}, 32'h3);
            check($sformatf("%h ready[%0d]", w, i), {30'd0, m_ready, l_ready}, 32'h0);
            check($sformatf("%h msb bit[%0d]", w, i), {31'd0, m_out}, {31'd0, word[15-i]});
            check($sformatf("%h lsb bit[%0d]", w, i), {31'd0, l_out}, {31'd0, word[i]});
            step();
        end
        check($sformatf("%h done pulse", w), {30'd0, m_done, l_done}, 32'h3);
        check($sformatf("%h done en", w),    {30'd0, m_en, l_en},     32'h0);
        check($sformatf("%h done busy", w),  {30'd0, m_busy, l_busy}, 32'h3);
        check($sformatf("%h done out", w),   {30'd0, m_out, l_out},   32'h0);
        step();
        check_idle($sformatf("%h post", w));
    endtask

    initial begin
        logic [3:0] nib;
        logic [1:0] sel;
        int         done_before;

        errors    = 0;
        checks    = 0;
        reset_n   = 1'b0;
        cfg_data  = 16'h0000;
        cfg_valid = 1'b0;
        abort     = 1'b0;

        // Reset held for three cycles, then handshake on the first edge after release.
        repeat (3) step();
        check_idle("reset");
        reset_n = 1'b1;
        run_load(16'hA5C3, 1'b0);

        // Chain holds the word; select 2'b10 on bits[3:0] = 4'h3 gives 0.
        check("chain word", {16'd0, chain}, 32'h0000_A5C3);
        nib = chain[3:0];
        sel = 2'b10;
        check("chain mux sel10", {31'd0, nib[sel]}, 32'h0);
        sel = 2'b00;
        check("chain mux sel00", {31'd0, nib[sel]}, 32'h1);

        // Abort on the 5th SHIFT cycle.
        done_before = done_cnt;
        cfg_data    = 16'hA5C3;
        cfg_valid   = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (4) step();
        check("abort shift5 en", {30'd0, m_en, l_en}, 32'h3);
        check("abort shift5 msb bit", {31'd0, m_out}, 32'h0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort");
        repeat (3) step();
        check("abort no done", done_cnt, done_before);
        check_idle("abort settled");

        // Clean load after abort; 16'h0001 exercises the LSB-first head bit.
        run_load(16'h0001, 1'b0);

        // Abort together with cfg_valid in IDLE is a normal handshake.
        run_load(16'h3C96, 1'b1);

        // Async reset between edges in the middle of a load.
        done_before = done_cnt;
        cfg_data    = 16'hFFFF;
        cfg_valid   = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (3) step();
        check("pre-reset en", {30'd0, m_en, l_en}, 32'h3);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async reset");
        step();
        reset_n = 1'b1;
        check("async reset no done", done_cnt, done_before);
        run_load(16'h5A01, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
